// File: rtl/inert_integrator_p.sv
// Gyro offset calibration, rate integration and optional accel fusion for pitch/roll/yaw.
// Latency: angle outputs and vld register one cycle after smpl_vld; cal_done one cycle after the last cal sample.
// Backpressure: none; every smpl_vld is consumed in its own cycle, strt_cal takes priority over smpl_vld.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   strt_cal                    pulse: start or restart calibration (from any state)
//   smpl_vld                    pulse: new sample on *_rt / *_acc
//   ptch_rt, roll_rt, yaw_rt    signed raw gyro rates
//   ptch_acc, roll_acc          signed accel-derived angles (fusion targets)
//   ptch, roll, yaw             signed integrated angles (registered)
//   vld                         pulse: angle outputs updated
//   cal_done                    pulse: calibration finished
//   calibrated                  level: offsets valid, integrating
module inert_integrator_p #(
    parameter int RATE_W     = 16,
    parameter int ANG_W      = 16,
    parameter int CAL_SHIFT  = 11,
    parameter int INT_SHIFT  = 8,
    parameter int FUSE_SHIFT = 5,
    parameter int FUSE_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    strt_cal,
    input  logic                    smpl_vld,
    input  logic signed [RATE_W-1:0] ptch_rt,
    input  logic signed [RATE_W-1:0] roll_rt,
    input  logic signed [RATE_W-1:0] yaw_rt,
    input  logic signed [ANG_W-1:0]  ptch_acc,
    input  logic signed [ANG_W-1:0]  roll_acc,
    output logic signed [ANG_W-1:0]  ptch,
    output logic signed [ANG_W-1:0]  roll,
    output logic signed [ANG_W-1:0]  yaw,
    output logic                    vld,
    output logic                    cal_done,
    output logic                    calibrated
);

    localparam int IW = ANG_W + INT_SHIFT;     // integrator width
    localparam int AW = RATE_W + CAL_SHIFT;    // calibration accumulator width
    localparam int SW = IW + 2;                // headroom for the update sum

    localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(IW-1){1'b0}}};
    localparam logic [CAL_SHIFT-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_CAL, S_RUN} state_t;

    state_t                  state;
    logic [CAL_SHIFT-1:0]    cnt;
    logic signed [AW-1:0]    acc    [3];
    logic signed [RATE_W-1:0] off   [3];
    logic signed [IW-1:0]    integ  [3];
    logic signed [ANG_W-1:0] ang_q  [3];

    logic signed [RATE_W-1:0] rt     [3];
    logic signed [ANG_W-1:0]  ang_in [3];
    logic signed [RATE_W:0]   comp   [3];
    logic signed [IW-1:0]     nxt_int[3];
    logic signed [AW-1:0]     cal_sum[3];

    assign rt[0]     = ptch_rt;
    assign rt[1]     = roll_rt;
    assign rt[2]     = yaw_rt;
    assign ang_in[0] = ptch_acc;
    assign ang_in[1] = roll_acc;
    assign ang_in[2] = '0;            // yaw has no absolute reference

    assign ptch = ang_q[0];
    assign roll = ang_q[1];
    assign yaw  = ang_q[2];

    // One integrator step: add compensated rate, optionally pull toward the
    // accel angle by 2^-FUSE_SHIFT of the error, then clamp to the IW range.
    function automatic logic signed [IW-1:0] int_step(
        input logic signed [IW-1:0]    cur,
        input logic signed [RATE_W:0]  cmp,
        input logic signed [ANG_W-1:0] tgt_ang,
        input logic                    fuse
    );
        logic signed [SW-1:0] cur_x;
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] tgt;
        logic signed [SW-1:0] err;
        cur_x = {{2{cur[IW-1]}}, cur};
        sum   = cur_x + {{(SW-RATE_W-1){cmp[RATE_W]}}, cmp};
        tgt   = {{2{tgt_ang[ANG_W-1]}}, tgt_ang, {INT_SHIFT{1'b0}}};
        err   = tgt - cur_x;
        if (fuse)
            sum = sum + (err >>> FUSE_SHIFT);
        if (sum > SAT_MAX)
            return SAT_MAX[IW-1:0];
        else if (sum < SAT_MIN)
            return SAT_MIN[IW-1:0];
        else
            return sum[IW-1:0];
    endfunction

    always_comb begin
        for (int a = 0; a < 3; a++) begin
            comp[a]    = {rt[a][RATE_W-1], rt[a]} - {off[a][RATE_W-1], off[a]};
            nxt_int[a] = int_step(integ[a], comp[a], ang_in[a], (FUSE_EN != 0) && (a < 2));
            cal_sum[a] = acc[a] + {{CAL_SHIFT{rt[a][RATE_W-1]}}, rt[a]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            vld        <= 1'b0;
            cal_done   <= 1'b0;
            calibrated <= 1'b0;
            for (int a = 0; a < 3; a++) begin
                acc[a]   <= '0;
                off[a]   <= '0;
                integ[a] <= '0;
                ang_q[a] <= '0;
            end
        end else begin
            vld      <= 1'b0;
            cal_done <= 1'b0;
            if (strt_cal) begin
                // Offsets are left alone: they stay in force until the new set loads.
                state      <= S_CAL;
                calibrated <= 1'b0;
                cnt        <= '0;
                for (int a = 0; a < 3; a++)
                    acc[a] <= '0;
            end else if (smpl_vld) begin
                case (state)
                    S_CAL: begin
                        for (int a = 0; a < 3; a++)
                            acc[a] <= cal_sum[a];
                        if (cnt == CNT_LAST) begin
                            // AW = RATE_W+CAL_SHIFT, so the upper RATE_W bits are
                            // exactly (sum >>> CAL_SHIFT) truncated to RATE_W.
                            for (int a = 0; a < 3; a++) begin
                                off[a]   <= cal_sum[a][CAL_SHIFT +: RATE_W];
                                integ[a] <= '0;
                                ang_q[a] <= '0;
                            end
                            cnt        <= '0;
                            state      <= S_RUN;
                            calibrated <= 1'b1;
                            cal_done   <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        for (int a = 0; a < 3; a++) begin
                            integ[a] <= nxt_int[a];
                            ang_q[a] <= nxt_int[a][IW-1:INT_SHIFT];
                        end
                        vld <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inert_integrator_p.sv
// Bench for inert_integrator_p: unfused (FUSE_EN=0) and fused (FUSE_SHIFT=4) instances on shared stimulus.
// Latency: model outputs follow each posedge; compared against both DUTs at every negedge.
// Backpressure: none; stimulus driven at negedges, strt_cal/smpl_vld pulses one cycle wide.
module tb_inert_integrator_p;

    localparam int  CS       = 3;
    localparam int  IS       = 8;
    localparam longint IMAX  = (longint'(1) <<< 23) - 1;
    localparam longint IMIN  = -(longint'(1) <<< 23);
    localparam int  M_IDLE   = 0;
    localparam int  M_CAL    = 1;
    localparam int  M_RUN    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic strt_cal = 1'b0;
    logic smpl_vld = 1'b0;
    logic signed [15:0] ptch_rt = '0, roll_rt = '0, yaw_rt = '0;
    logic signed [15:0] ptch_acc = '0, roll_acc = '0;

    logic signed [15:0] o_p [2];
    logic signed [15:0] o_r [2];
    logic signed [15:0] o_y [2];
    logic               o_vld [2];
    logic               o_done [2];
    logic               o_cal [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inert_integrator_p #(.RATE_W(16), .ANG_W(16), .CAL_SHIFT(CS), .INT_SHIFT(IS),
                         .FUSE_SHIFT(5), .FUSE_EN(0)) u_nf (
        .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .smpl_vld(smpl_vld),
        .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
        .ptch_acc(ptch_acc), .roll_acc(roll_acc),
        .ptch(o_p[0]), .roll(o_r[0]), .yaw(o_y[0]),
        .vld(o_vld[0]), .cal_done(o_done[0]), .calibrated(o_cal[0])
    );

    inert_integrator_p #(.RATE_W(16), .ANG_W(16), .CAL_SHIFT(CS), .INT_SHIFT(IS),
                         .FUSE_SHIFT(4), .FUSE_EN(1)) u_fu (
        .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .smpl_vld(smpl_vld),
        .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
        .ptch_acc(ptch_acc), .roll_acc(roll_acc),
        .ptch(o_p[1]), .roll(o_r[1]), .yaw(o_y[1]),
        .vld(o_vld[1]), .cal_done(o_done[1]), .calibrated(o_cal[1])
    );

    // ---------------- reference model ----------------
    int     m_mode = M_IDLE;
    int     m_cnt  = 0;
    longint m_sum [3] = '{0, 0, 0};
    longint m_off [3] = '{0, 0, 0};
    longint m_int [2][3] = '{'{0, 0, 0}, '{0, 0, 0}};
    longint e_ang [2][3] = '{'{0, 0, 0}, '{0, 0, 0}};
    bit     e_vld  = 1'b0;
    bit     e_done = 1'b0;
    bit     e_cal  = 1'b0;

    // floor(x / 2^k) with ordinary integer division
    function automatic longint floor_div(longint x, int k);
        longint d = longint'(1) <<< k;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic longint clamp(longint v);
        if (v > IMAX) return IMAX;
        if (v < IMIN) return IMIN;
        return v;
    endfunction

    function automatic longint model_step(longint cur, longint comp, longint ang, bit fuse, int fsh);
        longint v = cur + comp;
        if (fuse) v = v + floor_div(ang * 256 - cur, fsh);
        return clamp(v);
    endfunction

    function automatic longint rt_of(int a);
        if (a == 0) return ptch_rt;
        if (a == 1) return roll_rt;
        return yaw_rt;
    endfunction

    function automatic longint acc_of(int a);
        if (a == 0) return ptch_acc;
        if (a == 1) return roll_acc;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_cnt  <= 0;
            e_vld  <= 1'b0;
            e_done <= 1'b0;
            e_cal  <= 1'b0;
            for (int a = 0; a < 3; a++) begin
                m_sum[a] <= 0;
                m_off[a] <= 0;
                for (int k = 0; k < 2; k++) begin
                    m_int[k][a] <= 0;
                    e_ang[k][a] <= 0;
                end
            end
        end else begin
            e_vld  <= 1'b0;
            e_done <= 1'b0;
            if (strt_cal) begin
                m_mode <= M_CAL;
                m_cnt  <= 0;
                e_cal  <= 1'b0;
                for (int a = 0; a < 3; a++) m_sum[a] <= 0;
            end else if (smpl_vld && m_mode == M_CAL) begin
                if (m_cnt == (1 << CS) - 1) begin
                    for (int a = 0; a < 3; a++) begin
                        m_off[a] <= floor_div(m_sum[a] + rt_of(a), CS);
                        for (int k = 0; k < 2; k++) begin
                            m_int[k][a] <= 0;
                            e_ang[k][a] <= 0;
                        end
                    end
                    m_mode <= M_RUN;
                    e_done <= 1'b1;
                    e_cal  <= 1'b1;
                end else begin
                    for (int a = 0; a < 3; a++) m_sum[a] <= m_sum[a] + rt_of(a);
                    m_cnt <= m_cnt + 1;
                end
            end else if (smpl_vld && m_mode == M_RUN) begin
                for (int k = 0; k < 2; k++)
                    for (int a = 0; a < 3; a++) begin
                        m_int[k][a] <= model_step(m_int[k][a], rt_of(a) - m_off[a], acc_of(a),
                                                  (k == 1) && (a < 2), 4);
                        e_ang[k][a] <= floor_div(model_step(m_int[k][a], rt_of(a) - m_off[a],
                                                  acc_of(a), (k == 1) && (a < 2), 4), IS);
                    end
                e_vld <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ptch[%0d]", k), o_p[k], e_ang[k][0]);
                check($sformatf("roll[%0d]", k), o_r[k], e_ang[k][1]);
                check($sformatf("yaw[%0d]", k),  o_y[k], e_ang[k][2]);
                check($sformatf("vld[%0d]", k),  o_vld[k], e_vld);
                check($sformatf("cal_done[%0d]", k), o_done[k], e_done);
                check($sformatf("calibrated[%0d]", k), o_cal[k], e_cal);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic sample(input logic signed [15:0] p, input logic signed [15:0] r,
                          input logic signed [15:0] y, input logic signed [15:0] pa,
                          input logic signed [15:0] ra);
        @(negedge clk);
        ptch_rt = p; roll_rt = r; yaw_rt = y; ptch_acc = pa; roll_acc = ra;
        smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
    endtask

    task automatic pulse_cal();
        @(negedge clk);
        strt_cal = 1'b1;
        @(negedge clk);
        strt_cal = 1'b0;
    endtask

    task automatic calibrate(input logic signed [15:0] p);
        pulse_cal();
        for (int i = 0; i < 8; i++) sample(p, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
    endtask

    initial begin
        logic signed [15:0] prev;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_calibrated", o_cal[0], 0);
        check("rst_ptch", o_p[0], 0);

        // IDLE ignores samples
        sample(16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        check("idle_no_vld", o_vld[0], 0);

        // Calibration: offsets 16 / -4 / 0
        pulse_cal();
        for (int i = 0; i < 7; i++) sample(16'sh0010, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
        check("cal_not_done_yet", o_cal[0], 0);
        sample(16'sh0010, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
        check("cal_done_pulse", o_done[0], 1);
        check("calibrated_set", o_cal[0], 1);
        check("model_off_p", m_off[0], 16);
        check("model_off_r", m_off[1], -4);
        check("model_off_y", m_off[2], 0);
        @(negedge clk);
        check("cal_done_one_cycle", o_done[0], 0);

        // Integration: +1 LSB of angle per sample
        for (int i = 0; i < 256; i++) begin
            sample(16'sh0110, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
            check("ptch_ramp", o_p[0], i + 1);
            check("roll_zero", o_r[0], 0);
        end
        check("ptch_end", o_p[0], 256);

        // Yaw saturation both ways
        for (int i = 0; i < 300; i++) begin
            sample(16'sh0010, -16'sd4, 16'sh7FFF, 16'sd0, 16'sd0);
            check("yaw_nonneg", (o_y[0] < 0) ? 1 : 0, 0);
        end
        check("yaw_sat_hi", o_y[0], 32767);
        for (int i = 0; i < 600; i++) sample(16'sh0010, -16'sd4, -16'sd32768, 16'sd0, 16'sd0);
        check("yaw_sat_lo", o_y[0], -32768);

        // Fusion toward accel angle 0x100
        calibrate(16'sh0010);
        prev = o_p[1];
        for (int i = 0; i < 60; i++) begin
            sample(16'sh0010, -16'sd4, 16'sd0, 16'sh0100, 16'sd0);
            check("fuse_monotonic", (o_p[1] >= prev) ? 1 : 0, 1);
            check("fuse_bounded", (o_p[1] <= 16'sh0100) ? 1 : 0, 1);
            prev = o_p[1];
        end
        check("fuse_reached", (o_p[1] >= 16'sh00F0) ? 1 : 0, 1);

        // Restart mid-calibration: only the new samples count
        pulse_cal();
        for (int i = 0; i < 5; i++) sample(16'sd100, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
        pulse_cal();
        for (int i = 0; i < 7; i++) sample(16'sd40, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
        check("restart_not_cal", o_cal[0], 0);
        sample(16'sd40, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
        check("restart_done", o_done[0], 1);
        check("model_off_new", m_off[0], 40);
        sample(16'sd40, -16'sd4, 16'sd0, 16'sd0, 16'sd0);
        check("restart_comp_zero", o_p[0], 0);

        // strt_cal + smpl_vld together in RUN
        @(negedge clk);
        ptch_rt = 16'sd1000;
        strt_cal = 1'b1;
        smpl_vld = 1'b1;
        @(negedge clk);
        strt_cal = 1'b0;
        smpl_vld = 1'b0;
        check("collide_no_vld", o_vld[0], 0);
        check("collide_uncal", o_cal[0], 0);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            strt_cal = ($urandom_range(0, 63) == 0);
            smpl_vld = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                ptch_rt = 16'($urandom); roll_rt = 16'($urandom); yaw_rt = 16'($urandom);
            end else begin
                ptch_rt = 16'($signed($urandom_range(0, 2047)) - 1024);
                roll_rt = 16'($signed($urandom_range(0, 2047)) - 1024);
                yaw_rt  = 16'($signed($urandom_range(0, 2047)) - 1024);
            end
            ptch_acc = 16'($urandom);
            roll_acc = 16'($urandom);
        end
        @(negedge clk);
        strt_cal = 1'b0;
        smpl_vld = 1'b0;

        // Reset mid-RUN
        calibrate(16'sh0010);
        for (int i = 0; i < 5; i++) sample(16'sh0010, -16'sd4, 16'sh0400, 16'sd0, 16'sd0);
        check("pre_rst_yaw", o_y[0], 20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_yaw", o_y[0], 0);
        check("arst_calibrated", o_cal[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample(16'sh0400, 16'sd0, 16'sh0400, 16'sd0, 16'sd0);
            check("post_rst_no_vld", o_vld[0], 0);
            check("post_rst_ptch", o_p[0], 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
